// File: rtl/pe_types.sv
// Shared mesh datapath types: packet format and mesh-edge port count.
package pe_types;

    localparam int MESH_EDGE_PORTS = 8;

    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [23:0] payload;
    } packet_t;

endpackage

// File: rtl/mesh_egress_arbiter_if.sv
// Egress merge bus: N show-ahead input heads on one side, one holding register on the other.
// master = arbiter, slave = surrounding FIFOs / consumer.
interface mesh_egress_arbiter_if #(
    parameter int N_PORTS = 8
);
    import pe_types::*;

    logic [N_PORTS-1:0] in_deq;
    logic [N_PORTS-1:0] in_empty;
    packet_t            in_rdata [N_PORTS];
    logic               out_deq;
    logic               out_empty;
    packet_t            out_rdata;

    modport master (
        output in_deq,
        input  in_empty,
        input  in_rdata,
        input  out_deq,
        output out_empty,
        output out_rdata
    );

    modport slave (
        input  in_deq,
        output in_empty,
        output in_rdata,
        output out_deq,
        input  out_empty,
        input  out_rdata
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first requester after ptr, scanning upward modulo N_PORTS.
// Latency: purely combinational. Backpressure: none, caller qualifies the grant.
// Reused by any arbiter that keeps its own pointer register.
module rr_pick #(
    parameter  int N_PORTS = 8,
    localparam int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [N_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        // ptr itself is checked last, giving it the lowest priority
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N_PORTS);
            if (!gnt_vld && req[idx]) begin
                gnt_vld      = 1'b1;
                gnt_idx      = idx;
                gnt[idx]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesh_egress_arbiter.sv
// Merges N mesh-edge egress streams into one, round-robin, with per-port packet counters and drain.
// Latency: grant in cycle t -> packet in holding register at t+1; one packet/cycle sustained.
// Backpressure: grants only while the holding register is empty or being popped in the same cycle.
module mesh_egress_arbiter
    import pe_types::*;
#(
    parameter  int N_PORTS = MESH_EDGE_PORTS,
    parameter  int CNT_W   = 16,
    localparam int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    mesh_egress_arbiter_if.master  bus,
    input  logic                   enable,
    input  logic                   drain_req,
    output logic                   drain_done,
    output logic [CNT_W-1:0]       pkt_cnt [N_PORTS],
    output logic [IDX_W-1:0]       last_grant
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               hold_vld;
    packet_t            hold_dat;
    logic [IDX_W-1:0]   ptr;

    logic [N_PORTS-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               slot_free;
    logic               grant;

    rr_pick #(.N_PORTS(N_PORTS)) u_pick (
        .req     (~bus.in_empty),
        .ptr     (ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    assign slot_free = !hold_vld || bus.out_deq;
    // rst gating keeps an input from being popped in a cycle whose load is discarded
    assign grant     = (state == S_RUN) && slot_free && pick_vld && !rst;
    assign bus.in_deq = grant ? pick_gnt : '0;

    assign bus.out_empty = !hold_vld;
    assign bus.out_rdata = hold_dat;
    assign drain_done    = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (drain_req)   state_nxt = S_DRAIN;
                else if (enable) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (drain_req)    state_nxt = S_DRAIN;
                else if (!enable) state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (!hold_vld) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (!drain_req) state_nxt = enable ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            hold_vld   <= 1'b0;
            hold_dat   <= '0;
            ptr        <= IDX_W'(N_PORTS - 1);
            last_grant <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                hold_vld   <= 1'b1;
                hold_dat   <= bus.in_rdata[pick_idx];
                ptr        <= pick_idx;
                last_grant <= pick_idx;
            end else if (bus.out_deq) begin
                hold_vld   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PORTS; i++) pkt_cnt[i] <= '0;
        end else if (grant && (pkt_cnt[pick_idx] != {CNT_W{1'b1}})) begin
            pkt_cnt[pick_idx] <= pkt_cnt[pick_idx] + 1'b1;
        end
    end

endmodule

// File: tb/tb_mesh_egress_arbiter.sv
// Directed bench for mesh_egress_arbiter: a 16-bit-counter and a 4-bit-counter instance share stimulus.
module tb_mesh_egress_arbiter;
    import pe_types::*;

    localparam int N = 8;

    logic clk;
    logic rst;
    logic enable;
    logic drain_req;
    logic done16, done4;
    logic [15:0] cnt16 [N];
    logic [3:0]  cnt4  [N];
    logic [2:0]  lg16, lg4;

    int n_cmp = 0;
    int n_bad = 0;

    packet_t q [N][$];

    mesh_egress_arbiter_if #(.N_PORTS(N)) bus0 ();
    mesh_egress_arbiter_if #(.N_PORTS(N)) bus1 ();

    assign bus1.in_empty = bus0.in_empty;
    assign bus1.out_deq  = bus0.out_deq;
    for (genvar g = 0; g < N; g++) begin : g_rd
        assign bus1.in_rdata[g] = bus0.in_rdata[g];
    end

    mesh_egress_arbiter #(.N_PORTS(N), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus0),
        .enable     (enable),
        .drain_req  (drain_req),
        .drain_done (done16),
        .pkt_cnt    (cnt16),
        .last_grant (lg16)
    );

    mesh_egress_arbiter #(.N_PORTS(N), .CNT_W(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus1),
        .enable     (enable),
        .drain_req  (drain_req),
        .drain_done (done4),
        .pkt_cnt    (cnt4),
        .last_grant (lg4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic packet_t mk(input int p, input int n);
        packet_t pk;
        pk.src     = 4'(p);
        pk.dst     = 4'hA;
        pk.payload = 24'(n * 16 + p + 1);
        return pk;
    endfunction

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            bus0.in_empty[i] = (q[i].size() == 0);
            bus0.in_rdata[i] = (q[i].size() != 0) ? q[i][0] : '0;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // captures this cycle's pops, advances to just after the edge, applies them
    task automatic tick();
        logic [N-1:0] d;
        #1;
        d = bus0.in_deq;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (d[i] && q[i].size() != 0) void'(q[i].pop_front());
        refresh();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        refresh();
        enable       = 1'b0;
        drain_req    = 1'b0;
        bus0.out_deq = 1'b0;
        rst          = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_deq;

        // reset state
        do_reset();
        settle();
        chk("rst_out_empty", bus0.out_empty, 1);
        chk("rst_out_rdata", bus0.out_rdata, 0);
        chk("rst_in_deq", bus0.in_deq, 0);
        chk("rst_drain_done", done16, 0);
        chk("rst_last_grant", lg16, 0);
        for (int i = 0; i < N; i++) chk("rst_pkt_cnt", cnt16[i], 0);

        // all ports busy, consumer always popping: 0..7 then 0 again
        for (int i = 0; i < N; i++) begin
            q[i].push_back(mk(i, 0));
            q[i].push_back(mk(i, 1));
        end
        refresh();
        enable       = 1'b1;
        bus0.out_deq = 1'b1;
        settle();
        chk("rr_idle_no_deq", bus0.in_deq, 0);
        tick();
        for (int k = 0; k <= 8; k++) begin
            settle();
            exp_deq = 8'd1 << (k % 8);
            chk("rr_in_deq", bus0.in_deq, exp_deq);
            chk("rr_in_deq_dut4", bus1.in_deq, exp_deq);
            if (k == 0) begin
                chk("rr_first_empty", bus0.out_empty, 1);
            end else begin
                chk("rr_out_empty", bus0.out_empty, 0);
                chk("rr_out_rdata", bus0.out_rdata, mk(k - 1, 0));
            end
            if (k == 8)
                for (int i = 0; i < N; i++) chk("rr_cnt_one", cnt16[i], 1);
            tick();
        end
        chk("rr_wrap_rdata", bus0.out_rdata, mk(0, 1));
        chk("rr_wrap_cnt0", cnt16[0], 2);

        // sparse requesters 2 and 5 with pointer parked at 3
        do_reset();
        q[3].push_back(mk(3, 0));
        refresh();
        enable       = 1'b1;
        bus0.out_deq = 1'b1;
        tick();
        settle();
        chk("sp_grant3", bus0.in_deq, 8'h08);
        tick();
        chk("sp_last_grant3", lg16, 3);
        q[2].push_back(mk(2, 0));
        q[2].push_back(mk(2, 1));
        q[5].push_back(mk(5, 0));
        q[5].push_back(mk(5, 1));
        refresh();
        settle();
        chk("sp_grant5a", bus0.in_deq, 8'h20);
        tick();
        settle();
        chk("sp_rdata5a", bus0.out_rdata, mk(5, 0));
        chk("sp_grant2a", bus0.in_deq, 8'h04);
        tick();
        settle();
        chk("sp_rdata2a", bus0.out_rdata, mk(2, 0));
        chk("sp_grant5b", bus0.in_deq, 8'h20);
        tick();
        settle();
        chk("sp_rdata5b", bus0.out_rdata, mk(5, 1));
        chk("sp_last_grant5", lg16, 5);

        // consumer stalled: A loads once and holds, then pop+refill with no bubble
        do_reset();
        q[0].push_back(mk(0, 10));
        q[0].push_back(mk(0, 11));
        refresh();
        enable = 1'b1;
        tick();
        settle();
        chk("bp_load_a", bus0.in_deq, 8'h01);
        tick();
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("bp_hold_no_deq", bus0.in_deq, 0);
            chk("bp_hold_rdata", bus0.out_rdata, mk(0, 10));
            chk("bp_hold_full", bus0.out_empty, 0);
            tick();
        end
        bus0.out_deq = 1'b1;
        settle();
        chk("bp_refill_deq", bus0.in_deq, 8'h01);
        tick();
        bus0.out_deq = 1'b0;
        settle();
        chk("bp_refill_rdata", bus0.out_rdata, mk(0, 11));
        chk("bp_no_bubble", bus0.out_empty, 0);

        // drain with the holding register full and input still pending
        q[0].push_back(mk(0, 12));
        q[0].push_back(mk(0, 13));
        refresh();
        drain_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("dr_no_deq", bus0.in_deq, 0);
            chk("dr_not_done", done16, 0);
            tick();
        end
        bus0.out_deq = 1'b1;
        settle();
        chk("dr_pop_no_deq", bus0.in_deq, 0);
        tick();
        bus0.out_deq = 1'b0;
        settle();
        chk("dr_emptied", bus0.out_empty, 1);
        chk("dr_done_early", done16, 0);
        tick();
        settle();
        chk("dr_done", done16, 1);
        drain_req = 1'b0;
        tick();
        settle();
        chk("dr_resume_deq", bus0.in_deq, 8'h01);
        chk("dr_left_done", done16, 0);
        tick();
        chk("dr_resume_rdata", bus0.out_rdata, mk(0, 12));

        // counter saturation: 20 grants to port 0
        do_reset();
        for (int n = 0; n < 22; n++) q[0].push_back(mk(0, n));
        refresh();
        enable       = 1'b1;
        bus0.out_deq = 1'b1;
        tick();
        for (int c = 0; c < 20; c++) tick();
        chk("sat_cnt4", cnt4[0], 15);
        chk("sat_cnt16", cnt16[0], 20);
        for (int i = 1; i < N; i++) chk("sat_other", cnt4[i], 0);

        // reset mid-operation: no pop in the reset cycle
        rst = 1'b1;
        settle();
        chk("mrst_no_deq", bus0.in_deq, 0);
        tick();
        rst = 1'b0;
        settle();
        chk("mrst_out_empty", bus0.out_empty, 1);
        chk("mrst_cnt16", cnt16[0], 0);
        chk("mrst_cnt4", cnt4[0], 0);
        chk("mrst_q_intact", q[0].size(), 2);
        chk("mrst_idle_no_deq", bus0.in_deq, 0);
        chk("mrst_last_grant", lg16, 0);
        tick();
        settle();
        chk("mrst_run_deq", bus0.in_deq, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
